dmem_arbiter: RTL

- Shares the single data-memory port (combinational read, synchronous write, byte-addressed, funct3-coded width) between two requesters.
- Requester 0 is the core load/store stage; requester 1 is the debug/DMA loader.
- Round-robin arbitration, one transaction in flight, alignment and range checking before any memory access.
- Sits between the requesters and the data memory; the memory-side ports connect one-to-one to the memory's control, address, data and funct3 pins.

---
 rtl/dmem_arbiter_pkg.sv | 26 ++
 rtl/dmem_access_check.sv | 49 ++++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 width codes, FSM
// state encoding and the access-size helper.
package dmem_arbiter_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given width code.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_LH, F3_LHU: return 3'd2;
      F3_LW:         return 3'd4;
      default:       return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check of a latched request: width code, store
// width, natural alignment and memory range (no address wrap).
module dmem_access_check
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  output logic              legal_c
);

  localparam int unsigned EXT_W = ADDR_W + 1;

  logic [EXT_W-1:0] last_byte;
  logic             f3_ok;
  logic             align_ok;
  logic             range_ok;

  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b1;
    case (funct3)
      F3_LB:  f3_ok = 1'b1;
      F3_LH: begin
        f3_ok    = 1'b1;
        align_ok = ~addr[0];
      end
      F3_LW: begin
        f3_ok    = 1'b1;
        align_ok = (addr[1:0] == 2'b00);
      end
      F3_LBU: f3_ok = ~we;
      F3_LHU: begin
        f3_ok    = ~we;
        align_ok = ~addr[0];
      end
      default: f3_ok = 1'b0;
    endcase

    // One extra bit keeps addresses near the top of the space from wrapping.
    last_byte = EXT_W'(addr) + EXT_W'(access_bytes(funct3)) - EXT_W'(1);
    range_ok  = (last_byte < EXT_W'(MEM_BYTES));
    legal_c   = f3_ok & align_ok & range_ok;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core LSU
// (requester 0) and the debug/DMA loader (requester 1); one transaction in flight.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [31:0]       req_wdata0,
  input  logic [31:0]       req_wdata1,
  input  logic [2:0]        req_funct3_0,
  input  logic [2:0]        req_funct3_1,
  output logic [1:0]        rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_read_data
);

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              grant_id;
  logic              accept;
  logic              legal_c;

  logic              lat_id;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [2:0]        lat_funct3;

  logic [31:0]       rsp_rdata_reg;
  logic              err_reg;

  dmem_access_check #(
    .ADDR_W   (ADDR_W),
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .we     (lat_we),
    .addr   (lat_addr),
    .funct3 (lat_funct3),
    .legal_c(legal_c)
  );

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id = ~last_grant;
    end else if (req_valid[1]) begin
      grant_id = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rst && (req_valid != 2'b00)) begin
          req_ready = grant_id ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_read  = legal_c & ~lat_we;
        mem_write = legal_c & lat_we;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = lat_id ? 2'b10 : 2'b01;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch: inputs are only sampled at the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
    end else if (accept) begin
      last_grant <= grant_id;
      lat_id     <= grant_id;
      lat_we     <= req_we[grant_id];
      lat_addr   <= grant_id ? req_addr1    : req_addr0;
      lat_wdata  <= grant_id ? req_wdata1   : req_wdata0;
      lat_funct3 <= grant_id ? req_funct3_1 : req_funct3_0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata_reg <= '0;
      err_reg       <= 1'b0;
    end else if (state == ST_ACCESS) begin
      rsp_rdata_reg <= (legal_c && !lat_we) ? mem_read_data : 32'h0;
      err_reg       <= ~legal_c;
    end
  end

  assign rsp_rdata      = rsp_rdata_reg;
  assign rsp_err        = err_reg;
  assign mem_address    = lat_addr;
  assign mem_write_data = lat_wdata;
  assign mem_funct3     = lat_funct3;

endmodule
